// File: rtl/pmod_pkg.sv
// Shared widths, event record and priority helper for the PMOD input debouncer.
package pmod_pkg;

  localparam int unsigned PMOD_W   = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned DB_CNT_W = 4;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             level;
  } pmod_evt_t;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [PMOD_W-1:0] v);
    logic [IDX_W-1:0] r;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PMOD_W; i++) begin
      if (v[i] && !found) begin
        r     = IDX_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pmod_db_chan.sv
// One PMOD line: 2-FF synchroniser, tick-based debounce counter and debounced level.
module pmod_db_chan #(
  parameter int unsigned DB_TICKS = 8
) (
  input  logic CLK_48,
  input  logic RST_N,
  input  logic tick,
  input  logic pad,
  output logic state,
  output logic flip
);
  import pmod_pkg::*;

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_TICKS - 1);

  logic [1:0]          sync_ff;
  logic [DB_CNT_W-1:0] cnt;
  logic                disagree;

  assign disagree = sync_ff[1] ^ state;
  assign flip     = tick && disagree && (cnt == CNT_LAST);

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      sync_ff <= '0;
      cnt     <= '0;
      state   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], pad};
      if (!disagree) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          state <= sync_ff[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + DB_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pmod_input_debouncer.sv
// Debounces 8 PMOD input lines and streams per-channel level changes over valid/ready.
module pmod_input_debouncer
  import pmod_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 48000000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned DB_TICKS = 8
) (
  input  logic              CLK_48,
  input  logic              RST_N,
  input  logic [PMOD_W-1:0] PMOD_IN,
  output logic [PMOD_W-1:0] STATE,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [IDX_W-1:0]  EVT_IDX,
  output logic              EVT_LEVEL,
  output logic              OVERRUN,
  input  logic              CLR_OVR
);

  localparam int unsigned PS_LAST = CLK_HZ / TICK_HZ - 1;
  localparam int unsigned PS_W    = (PS_LAST > 0) ? $clog2(PS_LAST + 1) : 1;

  logic [PS_W-1:0]   ps;
  logic              tick;
  logic [PMOD_W-1:0] flip;
  logic [PMOD_W-1:0] state_now;
  logic [PMOD_W-1:0] pend;
  logic [PMOD_W-1:0] pend_next;
  logic [PMOD_W-1:0] clr_mask;
  logic [IDX_W-1:0]  sel;
  logic              load;
  logic              take;
  logic              ovr_set;
  pmod_evt_t         evt_next;

  assign tick = (ps == PS_W'(PS_LAST));

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      ps <= '0;
    end else begin
      ps <= tick ? '0 : ps + PS_W'(1);
    end
  end

  for (genvar g = 0; g < PMOD_W; g++) begin : g_chan
    pmod_db_chan #(
      .DB_TICKS(DB_TICKS)
    ) u_chan (
      .CLK_48(CLK_48),
      .RST_N (RST_N),
      .tick  (tick),
      .pad   (PMOD_IN[g]),
      .state (STATE[g]),
      .flip  (flip[g])
    );
  end

  // Level reported with an event is the post-edge value, so fold in this cycle's flips.
  assign state_now = STATE ^ flip;

  always_comb begin
    load     = !EVT_VALID || EVT_READY;
    sel      = lowest_set(pend);
    take     = load && (pend != '0);
    clr_mask = '0;
    if (take) begin
      clr_mask[sel] = 1'b1;
    end
    // A new flip re-arms a bit being drained this cycle without counting as overrun.
    ovr_set        = |(flip & pend & ~clr_mask);
    pend_next      = (pend & ~clr_mask) | flip;
    evt_next.idx   = sel;
    evt_next.level = state_now[sel];
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pend      <= '0;
      OVERRUN   <= 1'b0;
      EVT_VALID <= 1'b0;
      EVT_IDX   <= '0;
      EVT_LEVEL <= 1'b0;
    end else begin
      pend <= pend_next;
      if (ovr_set) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVR) begin
        OVERRUN <= 1'b0;
      end
      if (load) begin
        EVT_VALID <= take;
        if (take) begin
          EVT_IDX   <= evt_next.idx;
          EVT_LEVEL <= evt_next.level;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmod_input_debouncer.sv
// Self-checking bench: constant-expectation scenario table, hand sequences and a random run against a reference model.
module tb_pmod_input_debouncer;
  import pmod_pkg::*;

  localparam int unsigned CLK_HZ   = 48000;
  localparam int unsigned TICK_HZ  = 1000;
  localparam int unsigned DB_TICKS = 8;
  localparam int          TPER     = CLK_HZ / TICK_HZ;

  logic       CLK_48 = 1'b0;
  logic       RST_N;
  logic [7:0] PMOD_IN;
  logic [7:0] STATE;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [2:0] EVT_IDX;
  logic       EVT_LEVEL;
  logic       OVERRUN;
  logic       CLR_OVR;

  pmod_input_debouncer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .DB_TICKS(DB_TICKS)
  ) dut (
    .CLK_48   (CLK_48),
    .RST_N    (RST_N),
    .PMOD_IN  (PMOD_IN),
    .STATE    (STATE),
    .EVT_VALID(EVT_VALID),
    .EVT_READY(EVT_READY),
    .EVT_IDX  (EVT_IDX),
    .EVT_LEVEL(EVT_LEVEL),
    .OVERRUN  (OVERRUN),
    .CLR_OVR  (CLR_OVR)
  );

  always #5 CLK_48 = ~CLK_48;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pad history queue, per-line run of disagreeing ticks, pending flags.
  int         m_ps;
  logic [7:0] m_q[$];
  int         m_run[8];
  logic [7:0] m_st, m_pend;
  logic       m_valid, m_lvl, m_ovr;
  logic [2:0] m_idx;

  task automatic model_reset();
    m_ps = 0;
    m_q.delete();
    m_q.push_back(8'h00);
    m_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_st = '0; m_pend = '0; m_valid = 1'b0; m_lvl = 1'b0; m_ovr = 1'b0; m_idx = '0;
  endtask

  task automatic model_step(input logic [7:0] pad, input logic ready, input logic clr);
    bit         tk;
    logic [7:0] sync, fl;
    int         k;
    bit         oset;
    tk   = (m_ps == TPER - 1);
    m_ps = tk ? 0 : m_ps + 1;
    sync = m_q.pop_front();
    m_q.push_back(pad);
    fl = '0;
    for (int i = 0; i < 8; i++) begin
      if (sync[i] == m_st[i]) m_run[i] = 0;
      else if (tk) begin
        m_run[i]++;
        if (m_run[i] == int'(DB_TICKS)) begin
          m_st[i] = sync[i]; m_run[i] = 0; fl[i] = 1'b1;
        end
      end
    end
    k = -1;
    if (!m_valid || ready) begin
      for (int i = 7; i >= 0; i--) if (m_pend[i]) k = i;
      if (k >= 0) begin
        m_idx = 3'(k); m_lvl = m_st[k]; m_valid = 1'b1;
      end else m_valid = 1'b0;
    end
    oset = 0;
    for (int i = 0; i < 8; i++) if (fl[i] && m_pend[i] && i != k) oset = 1;
    if (k >= 0) m_pend[k] = 1'b0;
    m_pend = m_pend | fl;
    if (oset) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  pmod_evt_t evq[$];

  task automatic step(input logic [7:0] pad, input logic ready, input logic clr);
    PMOD_IN = pad; EVT_READY = ready; CLR_OVR = clr;
    if (EVT_VALID === 1'b1 && ready) evq.push_back('{idx: EVT_IDX, level: EVT_LEVEL});
    @(posedge CLK_48);
    model_step(pad, ready, clr);
    @(negedge CLK_48);
    check("model", {18'b0, STATE, EVT_VALID, EVT_IDX, EVT_LEVEL, OVERRUN},
                   {18'b0, m_st, m_valid, m_idx, m_lvl, m_ovr});
  endtask

  typedef struct {
    logic [7:0] pad;
    bit         ready;
    bit         clr;
    int         cycles;
    logic [7:0] st;
    bit         valid;
    bit         ovr;
    int         nevt;
    logic [2:0] idx;
    bit         lvl;
  } vec_t;

  vec_t vt[$];

  task automatic run_row(input int r);
    evq.delete();
    repeat (vt[r].cycles) step(vt[r].pad, vt[r].ready, vt[r].clr);
    check($sformatf("row%0d_state", r), {24'b0, STATE}, {24'b0, vt[r].st});
    check($sformatf("row%0d_valid", r), {31'b0, EVT_VALID}, {31'b0, vt[r].valid});
    check($sformatf("row%0d_ovr", r), {31'b0, OVERRUN}, {31'b0, vt[r].ovr});
    check($sformatf("row%0d_nevt", r), evq.size(), vt[r].nevt);
    if (vt[r].nevt > 0 && evq.size() > 0) begin
      check($sformatf("row%0d_idx", r), {29'b0, evq[$].idx}, {29'b0, vt[r].idx});
      check($sformatf("row%0d_lvl", r), {31'b0, evq[$].level}, {31'b0, vt[r].lvl});
    end
  endtask

  initial begin
    logic [7:0] pad;
    RST_N = 1'b0; PMOD_IN = '0; EVT_READY = 1'b0; CLR_OVR = 1'b0;
    model_reset();
    // pad, ready, clr, cycles, state, valid, ovr, nevt, last idx, last level
    vt.push_back('{8'h00, 1, 0, 2000, 8'h00, 0, 0, 0, 3'd0, 0});  // 0 idle
    vt.push_back('{8'h08, 1, 0, 389,  8'h08, 0, 0, 1, 3'd3, 1});  // 1 ch3 rise, worst-case bound
    vt.push_back('{8'h28, 1, 0, 144,  8'h08, 0, 0, 0, 3'd0, 0});  // 2 ch5 glitch 3 ticks
    vt.push_back('{8'h08, 1, 0, 600,  8'h08, 0, 0, 0, 3'd0, 0});  // 3 glitch gone
    vt.push_back('{8'h89, 0, 0, 400,  8'h89, 1, 0, 0, 3'd0, 0});  // 4 ch0+ch7 together, stalled
    vt.push_back('{8'h89, 1, 0, 5,    8'h89, 0, 0, 2, 3'd7, 1});  // 5 drain
    vt.push_back('{8'h8B, 0, 0, 450,  8'h8B, 1, 0, 0, 3'd0, 0});  // 6 ch1 occupies event reg
    vt.push_back('{8'h8F, 0, 0, 450,  8'h8F, 1, 0, 0, 3'd0, 0});  // 7 ch2 rise pending
    vt.push_back('{8'h8B, 0, 0, 450,  8'h8B, 1, 1, 0, 3'd0, 0});  // 8 ch2 fall -> overrun
    vt.push_back('{8'h8B, 1, 0, 5,    8'h8B, 0, 1, 2, 3'd2, 0});  // 9 drain ch1, ch2 level 0
    vt.push_back('{8'h8B, 1, 1, 1,    8'h8B, 0, 0, 0, 3'd0, 0});  // 10 clear overrun
    vt.push_back('{8'h8B, 1, 0, 20,   8'h8B, 0, 0, 0, 3'd0, 0});  // 11 stays clear
    vt.push_back('{8'h81, 1, 0, 400,  8'h81, 0, 0, 2, 3'd7, 1});  // 12 after reset: rising events

    repeat (3) @(negedge CLK_48);
    check("rst_state", {24'b0, STATE}, 32'h0);
    check("rst_valid", {31'b0, EVT_VALID}, 32'h0);
    check("rst_ovr", {31'b0, OVERRUN}, 32'h0);
    RST_N = 1'b1;

    for (int r = 0; r <= 4; r++) run_row(r);
    for (int c = 0; c < 10; c++) begin
      step(8'h89, 1'b0, 1'b0);
      check("stall_valid", {31'b0, EVT_VALID}, 32'h1);
      check("stall_idx", {29'b0, EVT_IDX}, 32'h0);
      check("stall_lvl", {31'b0, EVT_LEVEL}, 32'h1);
    end
    run_row(5);
    if (evq.size() == 2) check("drain_first_idx", {29'b0, evq[0].idx}, 32'h0);
    for (int r = 6; r <= 9; r++) run_row(r);
    if (evq.size() == 2) begin
      check("ovr_first_idx", {29'b0, evq[0].idx}, 32'h1);
      check("ovr_first_lvl", {31'b0, evq[0].level}, 32'h1);
    end
    run_row(10);
    run_row(11);

    // Random segments: mixed short glitches and long holds, random backpressure and clears.
    pad = 8'h8B;
    for (int s = 0; s < 40; s++) begin
      int hold;
      pad  = pad ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 150) : $urandom_range(380, 520);
      for (int c = 0; c < hold; c++)
        step(pad, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    // Force a held event, then reset asynchronously between clock edges.
    for (int c = 0; c < 450; c++) step(~pad, 1'b0, 1'b0);
    check("pre_rst_valid", {31'b0, EVT_VALID}, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_state", {24'b0, STATE}, 32'h0);
    check("arst_valid", {31'b0, EVT_VALID}, 32'h0);
    check("arst_idx", {29'b0, EVT_IDX}, 32'h0);
    check("arst_lvl", {31'b0, EVT_LEVEL}, 32'h0);
    check("arst_ovr", {31'b0, OVERRUN}, 32'h0);
    model_reset();
    repeat (3) @(negedge CLK_48);
    RST_N = 1'b1;
    run_row(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmod_input_debouncer.md
Name: pmod_input_debouncer

Overview:
- Input-side counterpart to the counter-driven LED/PMOD output logic on the CHOPIN board.
- Samples 8 PMOD lines as inputs (buttons/switches on a PMOD header) and synchronises and debounces each line.
- Presents debounced levels plus a one-at-a-time change-event stream with a valid/ready handshake to downstream logic.

Parameters:
- CLK_HZ, 48000000, CLK_48 frequency in Hz.
- TICK_HZ, 1000, debounce sample-tick rate in Hz; the prescaler terminal count is CLK_HZ/TICK_HZ-1.
- DB_TICKS, 8, consecutive ticks a line must disagree with its debounced state before that state flips. Range 2..15.

Ports:
- CLK_48  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- PMOD_IN  in  8  raw asynchronous pad inputs, bit i = channel i.
- STATE  out  8  debounced levels.
- EVT_VALID  out  1  event available.
- EVT_READY  in  1  consumer accepts the event.
- EVT_IDX  out  3  channel of the current event.
- EVT_LEVEL  out  1  new debounced level of that channel.
- OVERRUN  out  1  sticky: a channel changed again while its previous event was still pending.
- CLR_OVR  in  1  clears OVERRUN.

Behaviour:
- Reset (RST_N low, asynchronous): synchroniser FFs, STATE, counters, prescaler, pend mask, EVT_VALID, EVT_IDX, EVT_LEVEL and OVERRUN all go to 0. All logic runs on CLK_48 rising edges.
- Synchroniser: 2-FF chain per bit; sync[i] is PMOD_IN[i] delayed 2 cycles.
- Prescaler: free-running counter 0..CLK_HZ/TICK_HZ-1. Tick is a single-cycle pulse issued when the counter is at its terminal count, after which the counter wraps to 0.
- Per-channel debounce, with a 4-bit counter cnt[i]:
  - Any cycle with sync[i]==STATE[i]: cnt[i] <= 0.
  - On a tick with sync[i]!=STATE[i]: if cnt[i]==DB_TICKS-1, then STATE[i] <= sync[i], cnt[i] <= 0, flip[i]=1 for that cycle. Otherwise cnt[i]++.
  - A glitch shorter than DB_TICKS ticks never changes STATE.
- Latency from a pad change to STATE: 2 cycles plus between (DB_TICKS-1) and DB_TICKS tick periods, plus 1 cycle.
- Pending mask pend[7:0]:
  - flip[i] sets pend[i].
  - If pend[i] is already set and not being cleared this cycle, OVERRUN <= 1.
- Event output register:
  - Load condition: EVT_VALID==0, or EVT_VALID && EVT_READY.
  - On load, if pend is non-zero: select the lowest-index set bit k, EVT_IDX <= k, EVT_LEVEL <= STATE[k] (value after any same-cycle update), EVT_VALID <= 1, clear pend[k].
  - On load with pend==0: EVT_VALID <= 0.
  - Back-to-back events are allowed, one per cycle when EVT_READY is held high.
- Handshake: EVT_IDX and EVT_LEVEL stay stable while EVT_VALID && !EVT_READY. EVT_VALID never drops without a handshake, except on reset.
- Simultaneous events:
  - flip[k] in the same cycle pend[k] is cleared by a load: the set wins, so pend[k] stays 1 and no OVERRUN is raised.
  - Multiple flips in one cycle are each recorded in pend and drained in index order.
  - CLR_OVR together with a new overrun condition: set wins.
- Reset mid-operation discards pending and in-flight events. After release, lines held high produce rising events once debounced (STATE starts at 0).

Decomposition:
- Shared package pmod_pkg:
  - PMOD_W = 8.
  - IDX_W = 3.
  - DB_CNT_W = 4.
  - event record typedef {idx, level}.
- One natural sub-module, pmod_db_chan: synchroniser, cnt and STATE bit for one channel; tick and pad bit in, state and flip out. Instantiated 8× in a generate loop.
- Prescaler, pending mask, priority select and handshake register stay in the top level.

Test Plan (bench uses CLK_HZ=48000, TICK_HZ=1000, so a tick every 48 cycles; DB_TICKS=8):
- Reset then idle inputs → STATE=0x00, EVT_VALID=0, OVERRUN=0 for 2000 cycles.
- PMOD_IN[3] 0→1 held, EVT_READY=1 → STATE[3] rises within 2+8×48+1 cycles; exactly one event with EVT_IDX=3, EVT_LEVEL=1.
- PMOD_IN[5] high for 3 ticks then low (glitch) → STATE unchanged, no event.
- PMOD_IN = 0x81 in one cycle, EVT_READY=0 until both pending → events drain as idx 0 then idx 7, both level 1; data stable while stalled.
- Channel 2 toggled twice, each held ≥9 ticks, EVT_READY=0 throughout → OVERRUN=1; after ready, one event idx 2 with level 0 (current state); CLR_OVR pulse → OVERRUN=0.
- RST_N asserted asynchronously while EVT_VALID=1 → EVT_VALID and all outputs 0 immediately, without waiting for a clock edge.
